// File: rtl/dc_wr_seq_pkg.sv
// Shared definitions for the data-cache store sequencer: state encoding and
// store-size decoding.
package dc_wr_seq_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WR1   = 3'd1;
  localparam logic [2:0] S_MISS1 = 3'd2;
  localparam logic [2:0] S_WR2   = 3'd3;
  localparam logic [2:0] S_MISS2 = 3'd4;

  localparam logic [3:0] SZ1_BYTES = 4'd1;
  localparam logic [3:0] SZ2_BYTES = 4'd2;
  localparam logic [3:0] SZ4_BYTES = 4'd4;
  localparam logic [3:0] SZ8_BYTES = 4'd8;

  localparam logic [7:0] MISS_CNT_MAX = 8'hFF;

  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    case (size)
      2'd0:    return SZ1_BYTES;
      2'd1:    return SZ2_BYTES;
      2'd2:    return SZ4_BYTES;
      default: return SZ8_BYTES;
    endcase
  endfunction

endpackage

// File: rtl/dc_wr_seq_line_inc.sv
// Next-line address for the second half of a line-crossing store; wraps at the
// top of the line address space. Purely combinational.
module line_inc #(
  parameter int W = 28
) (
  input  logic [W-1:0] i_line,
  output logic [W-1:0] o_line
);

  assign o_line = i_line + W'(1);

endmodule

// File: rtl/dc_wr_seq.sv
// Store sequencer: accepts one store in IDLE, issues one or two line writes (split
// stores), and waits for fills on misses. Unsplit hit takes 2 cycles; st_ready is low until done.
module dc_wr_seq
  import dc_wr_seq_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int LINE_OFF_W = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         st_valid,
  output logic                         st_ready,
  input  logic [ADDR_W-1:0]            st_addr,
  input  logic [1:0]                   st_size,
  input  logic [63:0]                  st_data,
  output logic [1:0]                   mem_wr_size,
  output logic [63:0]                  mem_wr_data,
  output logic [LINE_OFF_W-1:0]        addr_offset,
  output logic                         access2_reg,
  output logic                         dc_wr_req,
  output logic [ADDR_W-LINE_OFF_W-1:0] dc_wr_line,
  input  logic                         dc_wr_hit,
  output logic                         dc_miss_req,
  input  logic                         dc_miss_ack,
  output logic                         st_busy,
  output logic [7:0]                   miss_cnt
);

  localparam int LINE_W = ADDR_W - LINE_OFF_W;
  localparam int SUM_W  = LINE_OFF_W + 1;
  localparam logic [SUM_W-1:0] LINE_BYTES = SUM_W'(1) << LINE_OFF_W;

  logic [2:0]        r_state;
  logic [2:0]        w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_size;
  logic [63:0]       r_data;
  logic [7:0]        r_miss_cnt;
  logic [LINE_W-1:0] w_line1;
  logic [LINE_W-1:0] w_line2;
  logic [SUM_W-1:0]  w_end;
  logic              w_split;
  logic              w_accept;
  logic              w_miss_enter;

  assign w_line1  = r_addr[ADDR_W-1:LINE_OFF_W];
  assign w_end    = SUM_W'(r_addr[LINE_OFF_W-1:0]) + SUM_W'(size_bytes(r_size));
  assign w_split  = w_end > LINE_BYTES;
  assign w_accept = (r_state == S_IDLE) && st_valid;

  line_inc #(.W(LINE_W)) u_line_inc (
    .i_line (w_line1),
    .o_line (w_line2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Acks only matter in the MISS states, so stray acks elsewhere fall through.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (st_valid) w_next = S_WR1;
      S_WR1: begin
        if (!dc_wr_hit)   w_next = S_MISS1;
        else if (w_split) w_next = S_WR2;
        else              w_next = S_IDLE;
      end
      S_MISS1: if (dc_miss_ack) w_next = S_WR1;
      S_WR2:   w_next = dc_wr_hit ? S_IDLE : S_MISS2;
      S_MISS2: if (dc_miss_ack) w_next = S_WR2;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    st_ready    = 1'b0;
    dc_wr_req   = 1'b0;
    dc_miss_req = 1'b0;
    access2_reg = 1'b0;
    case (r_state)
      S_IDLE:  st_ready = 1'b1;
      S_WR1:   dc_wr_req = 1'b1;
      S_MISS1: dc_miss_req = 1'b1;
      S_WR2: begin
        dc_wr_req   = 1'b1;
        access2_reg = 1'b1;
      end
      S_MISS2: begin
        dc_miss_req = 1'b1;
        access2_reg = 1'b1;
      end
      default: st_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
      r_size <= '0;
      r_data <= '0;
    end else if (w_accept) begin
      r_addr <= st_addr;
      r_size <= st_size;
      r_data <= st_data;
    end
  end

  assign w_miss_enter = dc_wr_req && !dc_wr_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_miss_cnt <= '0;
    else if (w_miss_enter && (r_miss_cnt != MISS_CNT_MAX))
      r_miss_cnt <= r_miss_cnt + 8'd1;
  end

  assign st_busy     = !st_ready;
  assign dc_wr_line  = access2_reg ? w_line2 : w_line1;
  assign mem_wr_size = r_size;
  assign mem_wr_data = r_data;
  assign addr_offset = r_addr[LINE_OFF_W-1:0];
  assign miss_cnt    = r_miss_cnt;

endmodule
